// File: rtl/pulse_measurer.sv
// Pulse width measurer: times high pulses on in_signal and presents the
// width through a single-entry valid/ready holding register.
module pulse_measurer (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_set,
    input  logic [7:0] in_value,
    output logic       out_ack,
    input  logic       in_signal,
    output logic [7:0] out_width,
    output logic       out_overflow,
    output logic       out_valid,
    input  logic       in_ready,
    output logic       out_dropped
);

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        MEASURE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] count;
    logic [7:0] count_next;
    logic       ovf;
    logic       ovf_next;
    logic       done;
    logic [7:0] min_width;
    logic       accept;
    logic       load;
    logic       drop;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state <= WAIT_LOW;
            count <= 8'd0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        ovf_next   = ovf;
        done       = 1'b0;
        unique case (state)
            WAIT_LOW: begin
                if (!in_signal) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (in_signal) begin
                    state_next = MEASURE;
                    count_next = 8'd1;
                    ovf_next   = 1'b0;
                end
            end
            MEASURE: begin
                if (in_signal) begin
                    // Saturate; any further high sample marks overflow.
                    if (count == 8'hFF) begin
                        ovf_next = 1'b1;
                    end else begin
                        count_next = count + 8'd1;
                    end
                end else begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: begin
                state_next = WAIT_LOW;
            end
        endcase
    end

    // min_width is the pre-update value here, so a coincident in_set
    // only affects later pulses.
    assign accept = done && (ovf || (count >= min_width));
    assign load   = accept && (!out_valid || in_ready);
    assign drop   = accept && out_valid && !in_ready;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            min_width <= 8'd1;
            out_ack   <= 1'b0;
        end else begin
            out_ack <= in_set;
            if (in_set) begin
                min_width <= (in_value == 8'd0) ? 8'd1 : in_value;
            end
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            out_width    <= 8'd0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
            out_dropped  <= 1'b0;
        end else begin
            out_dropped <= drop;
            if (load) begin
                out_width    <= count;
                out_overflow <= ovf;
                out_valid    <= 1'b1;
            end else if (in_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_measurer.sv
// Scoreboard bench for pulse_measurer: run-length reference model feeds
// an expected-result queue that a negedge monitor drains.
module tb_pulse_measurer;

    logic       clk = 1'b0;
    logic       in_reset = 1'b1;
    logic       in_set = 1'b0;
    logic [7:0] in_value = 8'd0;
    logic       in_signal = 1'b0;
    logic       in_ready = 1'b1;
    logic       out_ack;
    logic [7:0] out_width;
    logic       out_overflow;
    logic       out_valid;
    logic       out_dropped;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int w;
        bit o;
    } res_t;

    res_t exp_q[$];
    bit   armed;
    bit   m_valid;
    bit   exp_ack;
    bit   exp_drop;
    int   run;
    int   minw;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    pulse_measurer dut (
        .in_clock    (clk),
        .in_reset    (in_reset),
        .in_set      (in_set),
        .in_value    (in_value),
        .out_ack     (out_ack),
        .in_signal   (in_signal),
        .out_width   (out_width),
        .out_overflow(out_overflow),
        .out_valid   (out_valid),
        .in_ready    (in_ready),
        .out_dropped (out_dropped)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: a pulse is a run of high samples after the first low
    // sample; it is reported on the low sample that ends it.
    always @(posedge clk) begin : model
        bit   acc;
        res_t r;
        acc = 1'b0;
        r.w = 0;
        r.o = 1'b0;
        if (in_reset) begin
            armed    = 1'b0;
            run      = 0;
            minw     = 1;
            m_valid  = 1'b0;
            exp_ack  = 1'b0;
            exp_drop = 1'b0;
            exp_q.delete();
        end else begin
            exp_ack  = in_set;
            exp_drop = 1'b0;
            if (!armed) begin
                armed = !in_signal;
            end else if (in_signal) begin
                run++;
            end else if (run > 0) begin
                r.o = (run > 255);
                r.w = r.o ? 255 : run;
                acc = r.o || (run >= minw);
                run = 0;
            end
            if (acc) begin
                if (!m_valid || in_ready) begin
                    exp_q.push_back(r);
                    m_valid = 1'b1;
                end else begin
                    exp_drop = 1'b1;
                end
            end else if (m_valid && in_ready) begin
                m_valid = 1'b0;
            end
            if (in_set) begin
                minw = (in_value == 8'd0) ? 1 : int'(in_value);
            end
        end
    end

    always @(negedge clk) begin : monitor
        res_t r;
        if (mon_en) begin
            chk("valid", out_valid, m_valid);
            chk("ack", out_ack, exp_ack);
            chk("dropped", out_dropped, exp_drop);
            if (out_valid && in_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", out_width, 32'hFFFF_FFFF);
                end else begin
                    r = exp_q.pop_front();
                    chk("width", out_width, r.w);
                    chk("overflow", out_overflow, r.o);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(int w, int gap);
        in_signal = 1'b1;
        repeat (w) tick();
        in_signal = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic config_min(int v);
        in_set   = 1'b1;
        in_value = 8'(v);
        tick();
        in_set = 1'b0;
    endtask

    initial begin
        int runleft;
        tick();
        mon_en = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("reset_width", out_width, 0);
        chk("reset_overflow", out_overflow, 0);
        in_reset = 1'b0;
        repeat (2) tick();

        pulse(5, 3);

        config_min(4);
        pulse(3, 3);
        pulse(4, 3);

        in_ready = 1'b0;
        pulse(6, 1);
        pulse(7, 3);
        in_ready = 1'b1;
        repeat (2) tick();

        config_min(0);
        pulse(1, 2);

        pulse(300, 2);
        pulse(2, 3);
        pulse(255, 2);
        pulse(256, 2);

        in_signal = 1'b1;
        in_reset  = 1'b1;
        repeat (2) tick();
        in_reset = 1'b0;
        repeat (10) tick();
        in_signal = 1'b0;
        tick();
        pulse(3, 3);

        in_signal = 1'b1;
        repeat (4) tick();
        in_reset = 1'b1;
        tick();
        in_reset  = 1'b0;
        in_signal = 1'b0;
        tick();
        pulse(2, 2);

        in_set   = 1'b1;
        in_value = 8'd3;
        repeat (3) tick();
        in_set = 1'b0;
        pulse(2, 2);
        in_signal = 1'b1;
        repeat (3) tick();
        in_signal = 1'b0;
        in_set    = 1'b1;
        in_value  = 8'd9;
        tick();
        in_set = 1'b0;
        tick();
        pulse(5, 2);
        config_min(1);

        in_ready = 1'b1;
        pulse(2, 1);
        pulse(3, 1);
        pulse(2, 3);

        runleft = 0;
        for (int i = 0; i < 600; i++) begin
            in_ready = ($urandom_range(0, 3) != 0);
            in_set   = ($urandom_range(0, 19) == 0);
            in_value = 8'($urandom_range(0, 6));
            if (runleft == 0) begin
                in_signal = ~in_signal;
                runleft = in_signal ? $urandom_range(1, 10) : $urandom_range(1, 3);
            end
            runleft--;
            tick();
        end

        in_signal = 1'b0;
        in_set    = 1'b0;
        in_ready  = 1'b1;
        repeat (5) tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_measurer.md
PULSE_MEASURER -- requirements
Module: pulse_measurer

Interface
REQ-001 SHALL have parameter-free ports only; all widths fixed as listed.
REQ-002 in_clock  input  1  single clock; all state updates on posedge.
REQ-003 in_reset  input  1  synchronous, active-high reset.
REQ-004 in_set  input  1  config strobe; loads minimum accepted width from in_value.
REQ-005 in_value  input  8  minimum accepted pulse width in cycles (0 treated as 1).
REQ-006 out_ack  output  1  one-cycle acknowledge of in_set.
REQ-007 in_signal  input  1  pulse stream to measure; sampled each posedge.
REQ-008 out_width  output  8  measured high width of last accepted pulse, in cycles.
REQ-009 out_overflow  output  1  qualifies out_width: pulse exceeded 255 cycles.
REQ-010 out_valid  output  1  result available.
REQ-011 in_ready  input  1  consumer accepts result when high with out_valid.
REQ-012 out_dropped  output  1  one-cycle pulse: completed result lost, holding register full.

Function
REQ-013 SHALL implement states WAIT_LOW, IDLE, MEASURE.
REQ-014 WAIT_LOW: stay while in_signal=1; go IDLE on first in_signal=0 sample (a pulse in progress at reset is never measured).
REQ-015 IDLE: on in_signal=1 sample go MEASURE with count=1; else stay.
REQ-016 MEASURE: each in_signal=1 sample increments count; count saturates at 255; any increment attempted at 255 sets overflow flag.
REQ-017 MEASURE: on in_signal=0 sample go IDLE; pulse completes with width=count (N consecutive high samples -> width N).
REQ-018 Completed pulse with width < min_width (and no overflow) SHALL be discarded silently: no out_valid, no out_dropped.
REQ-019 Accepted pulse loads out_width=count, out_overflow=flag, out_valid=1 at the completing edge; visible the following cycle.
REQ-020 out_width/out_overflow SHALL stay stable while out_valid=1 and not consumed.
REQ-021 Consumption: out_valid=1 and in_ready=1 at an edge -> out_valid=0 next cycle, unless a new accepted result loads at the same edge, then out_valid stays 1 with new data.
REQ-022 Accepted result completing while out_valid=1 and in_ready=0 SHALL be discarded; out_dropped=1 for exactly the next cycle; held result unchanged.
REQ-023 Single-cycle low gap between pulses SHALL be sufficient: completing edge and next rising sample handled back-to-back without loss.
REQ-024 in_set=1 at an edge: min_width<=max(in_value,1); out_ack=1 the next cycle, 0 otherwise; in_set held N cycles -> out_ack high N cycles.
REQ-025 in_set coincident with a completing edge: comparison uses the old min_width.
REQ-026 in_ready without out_valid SHALL have no effect.
REQ-027 Configuration and measurement SHALL operate independently and concurrently.

Reset
REQ-028 in_reset=1 at an edge: state=WAIT_LOW, count=0, overflow flag=0, min_width=1.
REQ-029 Outputs after reset: out_ack=0, out_valid=0, out_width=0, out_overflow=0, out_dropped=0.
REQ-030 Reset SHALL override in_set, in_signal, in_ready in the same cycle; mid-pulse reset abandons the pulse without report.

Verification
REQ-031 Reset, in_signal low, in_ready=1; 5-cycle high pulse -> out_valid one cycle, out_width=5, out_overflow=0.
REQ-032 in_set with in_value=4 -> out_ack next cycle; 3-cycle pulse -> no out_valid; 4-cycle pulse -> out_width=4.
REQ-033 in_ready=0; pulses of 6 then 7 (1-cycle gap) -> out_width=6 held, out_dropped one cycle after second pulse; in_ready=1 -> out_valid clears.
REQ-034 300-cycle pulse -> out_width=255, out_overflow=1; next 2-cycle pulse -> out_width=2, out_overflow=0.
REQ-035 in_signal high across reset release for 10 cycles -> no result; following 3-cycle pulse -> out_width=3.
REQ-036 in_ready=1 held; pulses 2,3,2 with 1-cycle gaps -> three results 2,3,2, no out_dropped.
